// File: rtl/fft_bin_assembler.sv
// Gathers a serial stream of FFT magnitude bins into a double-buffered 16-bin
// parallel frame for mel_filterbank, realigning on s_last after framing errors.
//
// state  | meaning
// FILL   | accepting bins into staging; a complete frame loads the output bank
// HOLD   | full frame waiting in staging; input stalled until the bank frees
// RESYNC | dropping beats until an s_last re-establishes frame alignment
module fft_bin_assembler #(
  parameter int NBINS = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic [DW-1:0] fft_output_0,
  output logic [DW-1:0] fft_output_1,
  output logic [DW-1:0] fft_output_2,
  output logic [DW-1:0] fft_output_3,
  output logic [DW-1:0] fft_output_4,
  output logic [DW-1:0] fft_output_5,
  output logic [DW-1:0] fft_output_6,
  output logic [DW-1:0] fft_output_7,
  output logic [DW-1:0] fft_output_8,
  output logic [DW-1:0] fft_output_9,
  output logic [DW-1:0] fft_output_10,
  output logic [DW-1:0] fft_output_11,
  output logic [DW-1:0] fft_output_12,
  output logic [DW-1:0] fft_output_13,
  output logic [DW-1:0] fft_output_14,
  output logic [DW-1:0] fft_output_15,
  output logic          frame_valid,
  input  logic          frame_ack,
  output logic [7:0]    frame_count,
  output logic          err_sync
);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    HOLD   = 2'd1,
    RESYNC = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(NBINS - 1);

  state_t        state_q, state_d;
  logic [3:0]    wr_idx_q, wr_idx_d;
  logic          err_q, err_d;
  logic          frame_valid_q, frame_valid_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic [DW-1:0] staging_q [NBINS];
  logic [DW-1:0] out_q     [NBINS];

  logic accept, bank_free;
  logic stage_we, load_direct, load_stage, load;

  assign s_ready   = (state_q != HOLD);
  assign accept    = s_valid && s_ready;
  assign bank_free = !frame_valid_q || frame_ack;
  assign load      = load_direct || load_stage;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FILL;
      wr_idx_q      <= '0;
      err_q         <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    err_d       = 1'b0;
    stage_we    = 1'b0;
    load_direct = 1'b0;
    load_stage  = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (wr_idx_q != LAST_IDX) begin
            if (s_last) begin
              wr_idx_d = '0;
              err_d    = 1'b1;
            end else begin
              stage_we = 1'b1;
              wr_idx_d = wr_idx_q + 4'd1;
            end
          end else if (!s_last) begin
            wr_idx_d = '0;
            err_d    = 1'b1;
            state_d  = RESYNC;
          end else begin
            wr_idx_d = '0;
            if (bank_free) begin
              load_direct = 1'b1;
            end else begin
              stage_we = 1'b1;
              state_d  = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (bank_free) begin
          load_stage = 1'b1;
          state_d    = FILL;
        end
      end
      RESYNC: begin
        if (accept && s_last) begin
          wr_idx_d = '0;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // A load overrides a same-edge ack so the new frame stays presented.
  always_comb begin
    frame_valid_d = frame_valid_q;
    frame_count_d = frame_count_q;
    if (load) begin
      frame_valid_d = 1'b1;
      frame_count_d = frame_count_q + 8'd1;
    end else if (frame_ack) begin
      frame_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (stage_we) staging_q[wr_idx_q] <= s_data;
  end

  // On a direct load the final bin bypasses staging and comes straight off s_data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NBINS; k++) out_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NBINS; k++)
        out_q[k] <= (load_direct && k == NBINS - 1) ? s_data : staging_q[k];
    end
  end

  assign fft_output_0  = out_q[0];
  assign fft_output_1  = out_q[1];
  assign fft_output_2  = out_q[2];
  assign fft_output_3  = out_q[3];
  assign fft_output_4  = out_q[4];
  assign fft_output_5  = out_q[5];
  assign fft_output_6  = out_q[6];
  assign fft_output_7  = out_q[7];
  assign fft_output_8  = out_q[8];
  assign fft_output_9  = out_q[9];
  assign fft_output_10 = out_q[10];
  assign fft_output_11 = out_q[11];
  assign fft_output_12 = out_q[12];
  assign fft_output_13 = out_q[13];
  assign fft_output_14 = out_q[14];
  assign fft_output_15 = out_q[15];

  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
  assign err_sync    = err_q;

endmodule

// File: tb/tb_fft_bin_assembler.sv
// Directed bench for fft_bin_assembler: framing, backpressure, error recovery
// and frame counter wrap, against hand-computed expected values.
module tb_fft_bin_assembler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic        s_last = 1'b0;
  logic [15:0] fo [16];
  logic        frame_valid;
  logic        frame_ack = 1'b0;
  logic [7:0]  frame_count;
  logic        err_sync;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int exp_err = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  fft_bin_assembler #(.NBINS(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .fft_output_0(fo[0]),   .fft_output_1(fo[1]),   .fft_output_2(fo[2]),
    .fft_output_3(fo[3]),   .fft_output_4(fo[4]),   .fft_output_5(fo[5]),
    .fft_output_6(fo[6]),   .fft_output_7(fo[7]),   .fft_output_8(fo[8]),
    .fft_output_9(fo[9]),   .fft_output_10(fo[10]), .fft_output_11(fo[11]),
    .fft_output_12(fo[12]), .fft_output_13(fo[13]), .fft_output_14(fo[14]),
    .fft_output_15(fo[15]),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .frame_count(frame_count), .err_sync(err_sync)
  );

  always @(negedge clk) if (rst && err_sync) err_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_beat(input logic [15:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [15:0] base, input logic [15:0] step);
    for (int k = 0; k < 16; k++)
      send_beat(16'(base + step * 16'(k)), k == 15);
  endtask

  task automatic chk_bank(input string tag, input logic [15:0] base, input logic [15:0] step);
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s_bin%0d", tag, k), 32'(fo[k]), 32'(16'(base + step * 16'(k))));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #17;
    chk("rst_fv", 32'(frame_valid), 0);
    chk("rst_cnt", 32'(frame_count), 0);
    chk("rst_err", 32'(err_sync), 0);
    chk("rst_ready", 32'(s_ready), 1);
    chk("rst_out0", 32'(fo[0]), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Nominal frame 100..1600
    send_frame(16'd100, 16'd100);
    s_valid = 1'b0;
    exp_cnt = 1;
    chk("nom_fv", 32'(frame_valid), 1);
    chk("nom_cnt", 32'(frame_count), 32'(exp_cnt));
    chk_bank("nom", 16'd100, 16'd100);
    @(posedge clk); #1;
    chk("nom_err", 32'(err_cnt), 0);

    // Reset mid-frame after 7 beats
    for (int k = 0; k < 7; k++) send_beat(16'(50 + k), 1'b0);
    s_valid = 1'b0;
    #2 rst = 1'b0;
    #2;
    chk("mrst_fv", 32'(frame_valid), 0);
    chk("mrst_cnt", 32'(frame_count), 0);
    chk_bank("mrst", 16'd0, 16'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    send_frame(16'd10, 16'd10);
    s_valid = 1'b0;
    exp_cnt = 1;
    chk("mrst_fr_cnt", 32'(frame_count), 32'(exp_cnt));
    chk_bank("mrst_fr", 16'd10, 16'd10);

    // Backpressure: free the bank, then two back-to-back frames with no ack
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    chk("bp_ackclr", 32'(frame_valid), 0);
    send_frame(16'd1000, 16'd1);
    exp_cnt++;
    chk("bp_a_out0", 32'(fo[0]), 1000);
    send_frame(16'd2000, 16'd1);
    s_valid = 1'b0;
    chk("bp_hold_ready", 32'(s_ready), 0);
    chk("bp_hold_cnt", 32'(frame_count), 32'(exp_cnt));
    chk("bp_hold_out15", 32'(fo[15]), 1015);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_stable_out0", 32'(fo[0]), 1000);
    chk("bp_stable_ready", 32'(s_ready), 0);
    frame_ack = 1'b1;
    @(posedge clk); #1;
    frame_ack = 1'b0;
    exp_cnt++;
    chk("bp_load_fv", 32'(frame_valid), 1);
    chk("bp_load_cnt", 32'(frame_count), 32'(exp_cnt));
    chk("bp_load_ready", 32'(s_ready), 1);
    chk_bank("bp_b", 16'd2000, 16'd1);

    // Early s_last on beat 5
    for (int k = 1; k <= 5; k++) send_beat(16'(k), k == 5);
    s_valid = 1'b0;
    exp_err++;
    chk("early_err_hi", 32'(err_sync), 1);
    @(posedge clk); #1;
    chk("early_err_lo", 32'(err_sync), 0);
    chk("early_out0", 32'(fo[0]), 2000);
    chk("early_cnt", 32'(frame_count), 32'(exp_cnt));
    frame_ack = 1'b1;
    send_frame(16'd1, 16'd1);
    s_valid = 1'b0;
    exp_cnt++;
    chk("early_fr_cnt", 32'(frame_count), 32'(exp_cnt));
    chk_bank("early_fr", 16'd1, 16'd1);
    chk("early_errcnt", 32'(err_cnt), 32'(exp_err));

    // Missing s_last, 3 junk beats, realign on the 4th
    for (int k = 0; k < 16; k++) send_beat(16'(9000 + k), 1'b0);
    exp_err++;
    chk("miss_err_hi", 32'(err_sync), 1);
    for (int k = 0; k < 3; k++) send_beat(16'd7777, 1'b0);
    send_beat(16'd8888, 1'b1);
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("miss_errcnt", 32'(err_cnt), 32'(exp_err));
    chk("miss_cnt", 32'(frame_count), 32'(exp_cnt));
    chk("miss_out15", 32'(fo[15]), 16);
    chk("miss_ready", 32'(s_ready), 1);
    send_frame(16'd500, 16'd3);
    s_valid = 1'b0;
    exp_cnt++;
    chk("miss_fr_cnt", 32'(frame_count), 32'(exp_cnt));
    chk_bank("miss_fr", 16'd500, 16'd3);
    chk("miss_errcnt2", 32'(err_cnt), 32'(exp_err));

    // Counter wrap: fresh reset then 257 frames with ack held high
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    for (int f = 0; f < 257; f++) begin
      send_frame(16'(f * 16), 16'd1);
      chk("wrap_out15", 32'(fo[15]), 32'(16'(f * 16 + 15)));
      if (f == 255) chk("wrap_cnt0", 32'(frame_count), 0);
    end
    s_valid = 1'b0;
    frame_ack = 1'b0;
    chk("wrap_cnt1", 32'(frame_count), 1);
    chk("wrap_fv", 32'(frame_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_bin_assembler.md
# fft_bin_assembler

Collects a serial stream of FFT magnitude bins and presents them as one stable, parallel 16-bin frame on `fft_output_0`…`fft_output_15`, the exact port set the mel_filterbank consumes. It is the writer side of that interface and sits between the FFT core and mel_filterbank. It double-buffers (staging plus output bank), so the FFT can stream the next frame while mel_filterbank still holds the current one. It uses `s_last` for frame alignment and recovers from misaligned streams.

## Interface
- `NBINS`, 16: bins per frame. Fixed at 16 for the mel_filterbank port set.
- `DW`, 16: bin width in bits.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low. Asserted when 0.
- `s_valid`  in  1  input beat valid.
- `s_ready`  out  1  block accepts a beat this cycle.
- `s_data`  in  DW  bin magnitude, unsigned.
- `s_last`  in  1  marks the final bin (index 15) of a frame.
- `fft_output_0` … `fft_output_15`  out  DW each  parallel frame. Bin k sits on `fft_output_k`.
- `frame_valid`  out  1  output bank holds an unconsumed frame.
- `frame_ack`  in  1  consumer has taken the frame.
- `frame_count`  out  8  frames loaded since reset, mod 256.
- `err_sync`  out  1  one-cycle pulse on a framing error.

## Operation
- Beat is accepted on an edge where `s_valid && s_ready`. Data is ignored otherwise.
- Write index `wr_idx` (0..15) places each accepted beat into `staging[wr_idx]`.
- States:
  - FILL (reset state): `s_ready`=1. Accepted beat with idx<15 and `s_last`=0: store the beat, `wr_idx++`.
  - FILL, early `s_last` (idx<15 and `s_last`=1): discard the partial frame, `wr_idx`=0, pulse `err_sync`, stay in FILL.
  - FILL, missing `s_last` (idx==15 and `s_last`=0): discard the frame, pulse `err_sync`, go to RESYNC.
  - FILL, good frame (idx==15 and `s_last`=1): frame complete, `wr_idx`=0.
    - If the output bank is free (`frame_valid`==0 or `frame_ack`==1), load it at this edge: bins 0..14 from staging, bin 15 from `s_data`. Stay in FILL.
    - Otherwise store bin 15 in staging and go to HOLD.
  - HOLD: `s_ready`=0. On the first edge where `frame_valid`==0 or `frame_ack`==1, load the output bank from staging and go to FILL.
  - RESYNC: `s_ready`=1. Accepted beats are dropped. An accepted beat with `s_last`=1 is also dropped, sets `wr_idx`=0 and goes to FILL. No further `err_sync`.
- `s_ready` is decoded combinationally from state only: 1 in FILL and RESYNC, 0 in HOLD. It never depends on `s_valid`.
- On each load:
  - `frame_valid`←1 and `frame_count`←`frame_count`+1, wrapping 255→0.
- Without a load:
  - `frame_ack` with `frame_valid`=1 clears `frame_valid` at that edge.
  - `frame_ack` with `frame_valid`=0 is ignored.
- Load and ack on the same edge: the load wins and `frame_valid` stays 1. The new frame replaces the old one.
- Output registers change only on a load and otherwise hold their value indefinitely.
- No arithmetic on data: bins pass through bit-exact, unsigned DW.

## Timing
- Reset (`rst`=0, async): all `fft_output_k`=0, `frame_valid`=0, `frame_count`=0, `err_sync`=0, state FILL, `wr_idx`=0, staging contents don't-care. After reset `s_ready`=1 (FILL).
- Reset mid-frame or in HOLD: the partial or pending frame is lost. The output bank clears to 0.
- Latency: last beat accepted at edge N with the bank free → new outputs and `frame_valid`=1 visible after edge N. From HOLD, the load occurs at the first edge where the bank is free.
- Throughput: one frame per 16 cycles with continuous `s_valid` and `frame_ack` keeping up. No bubble.
- `err_sync` is high for exactly the cycle after the offending edge.

## Test plan
- Reset mid-frame: 7 beats accepted, `rst` pulsed low → all outputs 0, `frame_valid`=0, `frame_count`=0. A following 16-beat frame loads correctly.
- Nominal: 16 beats, values 100,200,…,1600, `s_last` on beat 16 → `fft_output_k`=100·(k+1), `frame_valid`=1 after the last edge, `frame_count`=1, `err_sync` never asserted.
- Backpressure: `frame_ack`=0, two frames streamed back-to-back → `s_ready`=0 after the second frame's last beat, and bank 1 stays stable. Pulse `frame_ack` → frame 2 loads on that edge, `frame_valid` stays 1, `s_ready`=1 next cycle, `frame_count`=2.
- Early `s_last` on beat 5 → `err_sync` pulses once, outputs and `frame_count` unchanged. The next 16 beats (1..16, `s_last` on 16th) load normally.
- Missing `s_last` on beat 16, then 3 junk beats, then `s_last` on the 4th → `err_sync` pulses once and all 20 beats are dropped. The next proper frame loads.
- 257 nominal frames with immediate ack → `frame_count` reads 1 after the wrap (255→0→1). Each frame's `fft_output_15` equals the last beat sent.
